// File: rtl/ictc_pkg.sv
// Shared ICTC definitions: bus widths, register map and bridge FSM states.
// Used by the APB bridge and by bank-side address decoders.
package ictc_pkg;

    localparam int ICTC_ADDR_W = 12;
    localparam int ICTC_DATA_W = 32;

    localparam logic [ICTC_ADDR_W-1:0] CTRL_ADDR = 12'h00;
    localparam logic [ICTC_ADDR_W-1:0] STAT_ADDR = 12'h04;
    localparam logic [ICTC_ADDR_W-1:0] PRE_ADDR  = 12'h08;
    localparam logic [ICTC_ADDR_W-1:0] CMP_ADDR  = 12'h0C;
    localparam logic [ICTC_ADDR_W-1:0] CNT_ADDR  = 12'h10;
    localparam logic [ICTC_ADDR_W-1:0] TIER_ADDR = 12'h14;
    localparam logic [ICTC_ADDR_W-1:0] TISR_ADDR = 12'h18;
    localparam logic [ICTC_ADDR_W-1:0] CAP_ADDR  = 12'h1C;

    localparam logic [ICTC_ADDR_W-1:0] ICTC_ADDR_MAX = CAP_ADDR;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } ictc_state_e;

    // Word-aligned and within the populated part of the bank.
    function automatic logic ictc_mapped(
        input logic [ICTC_ADDR_W-1:0] addr,
        input logic [ICTC_ADDR_W-1:0] addr_max
    );
        return (addr[1:0] == 2'b00) && (addr <= addr_max);
    endfunction

endpackage

// File: rtl/ictc_addr_decode.sv
// Combinational mapped/unmapped check for ICTC register addresses.
// Shared by the APB bridge and bank-side decoders.
module ictc_addr_decode
    import ictc_pkg::*;
#(
    parameter logic [ICTC_ADDR_W-1:0] ADDR_MAX = ICTC_ADDR_MAX
) (
    input  logic [ICTC_ADDR_W-1:0] i_addr,
    output logic                   o_mapped
);

    assign o_mapped = ictc_mapped(i_addr, ADDR_MAX);

endmodule

// File: rtl/ictc_apb_reg_bridge.sv
// APB3 completer driving the ICTC register bank with programmable wait states.
// Optional error response on pslverr when ICTC_APB_PSLVERR_EN is defined.
module ictc_apb_reg_bridge
    import ictc_pkg::*;
#(
    parameter int                     WAIT_STATES = 1,
    parameter logic [ICTC_ADDR_W-1:0] ADDR_MAX    = 12'h1C
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [ICTC_ADDR_W-1:0] paddr,
    input  logic [ICTC_DATA_W-1:0] pwdata,
    output logic                   pready,
    output logic [ICTC_DATA_W-1:0] prdata,
    output logic                   pslverr,
    output logic [ICTC_ADDR_W-1:0] reg_addr,
    output logic [ICTC_DATA_W-1:0] reg_wr_data,
    output logic                   reg_wr_en,
    input  logic [ICTC_DATA_W-1:0] reg_rd_data
);

    localparam logic [3:0] LP_LAST = 4'(WAIT_STATES - 1);

    ictc_state_e            r_state;
    logic [3:0]             r_cnt;
    logic                   r_wr_q;
    logic                   r_err_q;
    logic                   r_pready;
    logic                   r_wr_en;
    logic [ICTC_DATA_W-1:0] r_prdata;
    logic [ICTC_ADDR_W-1:0] r_addr;
    logic [ICTC_DATA_W-1:0] r_wdata;
    logic                   w_mapped;

`ifdef ICTC_APB_PSLVERR_EN
    logic r_pslverr;
    assign pslverr = r_pslverr;
`else
    assign pslverr = 1'b0;
`endif

    ictc_addr_decode #(
        .ADDR_MAX (ADDR_MAX)
    ) u_dec (
        .i_addr   (paddr),
        .o_mapped (w_mapped)
    );

    assign pready      = r_pready;
    assign prdata      = r_prdata;
    assign reg_addr    = r_addr;
    assign reg_wr_data = r_wdata;
    assign reg_wr_en   = r_wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_wr_q   <= 1'b0;
            r_err_q  <= 1'b0;
            r_pready <= 1'b0;
            r_wr_en  <= 1'b0;
            r_prdata <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
`ifdef ICTC_APB_PSLVERR_EN
            r_pslverr <= 1'b0;
`endif
        end else begin
            r_pready <= 1'b0;
            r_wr_en  <= 1'b0;
`ifdef ICTC_APB_PSLVERR_EN
            r_pslverr <= 1'b0;
`endif
            unique case (r_state)
                ST_IDLE: begin
                    if (psel && !penable) begin
                        r_addr  <= paddr;
                        r_wdata <= pwdata;
                        r_wr_q  <= pwrite;
                        r_err_q <= !w_mapped;
                        r_cnt   <= 4'd0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (!psel) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == LP_LAST) begin
                        // Bank data sampled in the last wait cycle is the read result.
                        r_prdata <= r_err_q ? '0 : reg_rd_data;
                        r_pready <= 1'b1;
                        r_wr_en  <= r_wr_q && !r_err_q;
`ifdef ICTC_APB_PSLVERR_EN
                        r_pslverr <= r_err_q;
`endif
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ictc_apb_reg_bridge.sv
// Bench for ictc_apb_reg_bridge: WAIT_STATES=1 and =3 instances, each with a bank model.
// Table-driven transfers plus abort, malformed access and mid-transfer reset sequences.
module tb_ictc_apb_reg_bridge;

    localparam bit PSLV =
`ifdef ICTC_APB_PSLVERR_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        psel        [2];
    logic        penable     [2];
    logic        pwrite      [2];
    logic [11:0] paddr       [2];
    logic [31:0] pwdata      [2];
    logic        pready      [2];
    logic [31:0] prdata      [2];
    logic        pslverr     [2];
    logic [11:0] reg_addr    [2];
    logic [31:0] reg_wr_data [2];
    logic        reg_wr_en   [2];
    logic [31:0] reg_rd_data [2];
    logic [31:0] bank        [2][8];

    int n_chk = 0;
    int n_err = 0;

    ictc_apb_reg_bridge #(
        .WAIT_STATES (1),
        .ADDR_MAX    (12'h1C)
    ) u_dut_ws1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .psel        (psel[0]),
        .penable     (penable[0]),
        .pwrite      (pwrite[0]),
        .paddr       (paddr[0]),
        .pwdata      (pwdata[0]),
        .pready      (pready[0]),
        .prdata      (prdata[0]),
        .pslverr     (pslverr[0]),
        .reg_addr    (reg_addr[0]),
        .reg_wr_data (reg_wr_data[0]),
        .reg_wr_en   (reg_wr_en[0]),
        .reg_rd_data (reg_rd_data[0])
    );

    ictc_apb_reg_bridge #(
        .WAIT_STATES (3),
        .ADDR_MAX    (12'h1C)
    ) u_dut_ws3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .psel        (psel[1]),
        .penable     (penable[1]),
        .pwrite      (pwrite[1]),
        .paddr       (paddr[1]),
        .pwdata      (pwdata[1]),
        .pready      (pready[1]),
        .prdata      (prdata[1]),
        .pslverr     (pslverr[1]),
        .reg_addr    (reg_addr[1]),
        .reg_wr_data (reg_wr_data[1]),
        .reg_wr_en   (reg_wr_en[1]),
        .reg_rd_data (reg_rd_data[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank model; unmapped addresses return junk the bridge must mask.
    for (genvar k = 0; k < 2; k++) begin : g_bank
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) bank[k][i] <= '0;
            end else if (reg_wr_en[k]) begin
                bank[k][reg_addr[k][4:2]] <= reg_wr_data[k];
            end
        end
        assign reg_rd_data[k] =
            (reg_addr[k] <= 12'h1C && reg_addr[k][1:0] == 2'b00) ?
            bank[k][reg_addr[k][4:2]] : 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_n && reg_wr_en[k] && !pready[k]) begin
                n_err++;
                $display("FAIL wen_outside_done dut%0d: reg_wr_en=1 pready=0 required wen=0", k);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic idle(input int k, input int n);
        @(negedge clk);
        psel[k]    = 1'b0;
        penable[k] = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic xfer(
        input  int          k,
        input  bit          wr,
        input  logic [11:0] a,
        input  logic [31:0] d,
        output bit          p0,
        output int          lat,
        output logic [31:0] rd,
        output bit          err,
        output int          wen_n,
        output logic [11:0] wa,
        output logic [31:0] wd
    );
        int c;
        bit done;
        lat = 0; rd = '0; err = 1'b0; wen_n = 0; wa = '0; wd = '0;
        @(negedge clk);
        p0         = pready[k];
        psel[k]    = 1'b1;
        penable[k] = 1'b0;
        pwrite[k]  = wr;
        paddr[k]   = a;
        pwdata[k]  = d;
        @(negedge clk);
        penable[k] = 1'b1;
        c = 1;
        done = 1'b0;
        while (!done && c <= 40) begin
            if (reg_wr_en[k]) begin
                wen_n++;
                wa = reg_addr[k];
                wd = reg_wr_data[k];
            end
            if (pready[k]) begin
                lat  = c;
                rd   = prdata[k];
                err  = pslverr[k];
                done = 1'b1;
            end else begin
                c++;
                @(negedge clk);
            end
        end
    endtask

    task automatic chk_rst(input int k);
        chk($sformatf("rst_ctl dut%0d", k), {61'd0, pready[k], pslverr[k], reg_wr_en[k]}, 64'd0);
        chk($sformatf("rst_prdata dut%0d", k), {32'd0, prdata[k]}, 64'd0);
        chk($sformatf("rst_addr dut%0d", k), {52'd0, reg_addr[k]}, 64'd0);
        chk($sformatf("rst_wdata dut%0d", k), {32'd0, reg_wr_data[k]}, 64'd0);
    endtask

    typedef struct {
        int          k;
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          unm;
        int          lat;
        int          gap;
    } vec_t;

    vec_t vt [14];

    initial begin
        bit          p0;
        int          lat;
        logic [31:0] rd;
        bit          err;
        int          wen_n;
        logic [11:0] wa;
        logic [31:0] wd;
        bit          seen;

        vt[0]  = '{0, 1'b1, 12'h014, 32'h0000_0001, 32'h0,          1'b0, 2, 0};
        vt[1]  = '{0, 1'b0, 12'h014, 32'h0,          32'h0000_0001, 1'b0, 2, 1};
        vt[2]  = '{0, 1'b1, 12'h000, 32'h1234_5678, 32'h0,          1'b0, 2, 0};
        vt[3]  = '{0, 1'b0, 12'h000, 32'h0,          32'h1234_5678, 1'b0, 2, 1};
        vt[4]  = '{0, 1'b1, 12'h01C, 32'hCAFE_F00D, 32'h0,          1'b0, 2, 1};
        vt[5]  = '{0, 1'b0, 12'h01C, 32'h0,          32'hCAFE_F00D, 1'b0, 2, 1};
        vt[6]  = '{0, 1'b1, 12'h020, 32'hFFFF_FFFF, 32'h0,          1'b1, 2, 1};
        vt[7]  = '{0, 1'b1, 12'h015, 32'h0000_0005, 32'h0,          1'b1, 2, 1};
        vt[8]  = '{0, 1'b0, 12'h020, 32'h0,          32'h0,          1'b1, 2, 1};
        vt[9]  = '{0, 1'b0, 12'h014, 32'h0,          32'h0000_0001, 1'b0, 2, 0};
        vt[10] = '{0, 1'b0, 12'h000, 32'h0,          32'h1234_5678, 1'b0, 2, 1};
        vt[11] = '{1, 1'b1, 12'h014, 32'hA5A5_0001, 32'h0,          1'b0, 4, 1};
        vt[12] = '{1, 1'b0, 12'h014, 32'h0,          32'hA5A5_0001, 1'b0, 4, 1};
        vt[13] = '{1, 1'b0, 12'h01E, 32'h0,          32'h0,          1'b1, 4, 1};

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
            paddr[k] = '0; pwdata[k] = '0;
        end
        repeat (3) @(negedge clk);
        chk_rst(0);
        chk_rst(1);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vt[i]) begin
            xfer(vt[i].k, vt[i].wr, vt[i].addr, vt[i].wd, p0, lat, rd, err, wen_n, wa, wd);
            chk($sformatf("v%0d pready_at_setup", i), {63'd0, p0}, 64'd0);
            chk($sformatf("v%0d latency", i), 64'(lat), 64'(vt[i].lat));
            chk($sformatf("v%0d pslverr", i), {63'd0, err}, {63'd0, vt[i].unm & PSLV});
            chk($sformatf("v%0d wen_pulses", i), 64'(wen_n), (vt[i].wr && !vt[i].unm) ? 64'd1 : 64'd0);
            if (vt[i].wr && !vt[i].unm) begin
                chk($sformatf("v%0d wen_addr", i), {52'd0, wa}, {52'd0, vt[i].addr});
                chk($sformatf("v%0d wen_data", i), {32'd0, wd}, {32'd0, vt[i].wd});
            end else if (!vt[i].wr) begin
                chk($sformatf("v%0d prdata", i), {32'd0, rd}, {32'd0, vt[i].exp_rd});
            end
            if (vt[i].gap > 0) idle(vt[i].k, vt[i].gap);
        end

        // Access phase without setup must never complete.
        @(negedge clk);
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = 12'h014; pwdata[0] = 32'h99;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (pready[0] || reg_wr_en[0]) seen = 1'b1;
        end
        chk("malformed_no_ready", {63'd0, seen}, 64'd0);
        xfer(0, 1'b0, 12'h014, 32'h0, p0, lat, rd, err, wen_n, wa, wd);
        chk("after_malformed latency", 64'(lat), 64'd2);
        chk("after_malformed prdata", {32'd0, rd}, 64'h1);
        idle(0, 1);

        // Abort a write in its second wait cycle.
        @(negedge clk);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 12'h014; pwdata[1] = 32'h1;
        @(negedge clk);
        penable[1] = 1'b1;
        @(negedge clk);
        psel[1] = 1'b0; penable[1] = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            if (pready[1] || reg_wr_en[1]) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_ready_no_wen", {63'd0, seen}, 64'd0);
        xfer(1, 1'b0, 12'h014, 32'h0, p0, lat, rd, err, wen_n, wa, wd);
        chk("after_abort latency", 64'(lat), 64'd4);
        chk("after_abort prdata", {32'd0, rd}, 64'hA5A5_0001);
        chk("after_abort wen", 64'(wen_n), 64'd0);
        idle(1, 2);

        // Reset in the middle of a write.
        @(negedge clk);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 12'h014; pwdata[1] = 32'h7;
        @(negedge clk);
        penable[1] = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_rst(0);
        chk_rst(1);
        psel[1] = 1'b0; penable[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1, 2);
        xfer(1, 1'b0, 12'h014, 32'h0, p0, lat, rd, err, wen_n, wa, wd);
        chk("post_reset latency", 64'(lat), 64'd4);
        chk("post_reset prdata", {32'd0, rd}, 64'd0);
        idle(1, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ictc_apb_reg_bridge.md
Name: ictc_apb_reg_bridge

Overview:
- APB3 completer that sits between the SoC APB fabric and the ICTC register bank.
- Turns APB transfers into the bank's register-side interface: addr, wr_data, wr_en, and muxed rd_data.
- Every register module, TIER at 12'h14 included, sees this block as its only initiator.
- Adds programmable wait states and a registered read path, so bank decode timing stays off the APB critical path.

Parameters:
- WAIT_STATES, 1, number of cycles pready is held low in the access phase; legal range 1..15.
- ADDR_MAX, 12'h1C, highest mapped word address in the bank.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- pwrite  in  1  1 = write, 0 = read
- paddr  in  12  APB byte address
- pwdata  in  32  APB write data
- pready  out  1  transfer complete
- prdata  out  32  read data, valid while pready=1
- pslverr  out  1  error response
- reg_addr  out  12  address to register bank
- reg_wr_data  out  32  write data to register bank
- reg_wr_en  out  1  single-cycle write strobe to register bank
- reg_rd_data  in  32  OR-muxed read data from register bank

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Reset values: state=IDLE, pready=0, prdata=0, pslverr=0, reg_addr=0, reg_wr_data=0, reg_wr_en=0, wait counter=0.
- FSM has 3 states.
- IDLE:
  - pready=0.
  - On psel=1 and penable=0 (setup phase, cycle T0): latch paddr into reg_addr, pwdata into reg_wr_data, pwrite into wr_q, and the decode result into err_q.
  - Clear the counter and go to WAIT.
- WAIT:
  - pready=0. Counter increments each cycle.
  - On every WAIT cycle, prdata_q <= reg_rd_data.
  - When counter == WAIT_STATES-1, go to DONE.
  - If psel=0 in any WAIT cycle, abort to IDLE: no reg_wr_en, prdata unchanged.
- DONE (cycle T0+WAIT_STATES+1):
  - pready=1 and prdata=prdata_q.
  - reg_wr_en=1 for this cycle only, if wr_q=1 and err_q=0; the bank updates on the edge that ends the transfer.
  - Next state is IDLE.
  - A back-to-back setup phase in the following cycle is accepted normally.
- Decode: an address is unmapped if paddr[1:0] != 0 or paddr > ADDR_MAX.
- pready is held low in IDLE even while psel=1 and penable=1. This covers a malformed access without setup; the FSM waits for a proper setup phase.
- reg_wr_en is never asserted outside DONE.
- reg_addr and reg_wr_data hold their last values between transfers.
- Read data returned is the bank value sampled in the last WAIT cycle. A write to the bank cannot coincide with a read, so there is no hazard.
- rst_n asserted mid-transfer: return to IDLE immediately, clear pready and reg_wr_en, and lose the transfer.
- Reads of unmapped addresses return prdata=0.
- Counter width is 4 bits; WAIT_STATES=15 must not wrap early.

Optional Feature:
- Macro: ICTC_APB_PSLVERR_EN.
- Defined:
  - pslverr = err_q during DONE, 0 otherwise.
  - An unmapped write suppresses reg_wr_en.
  - An unmapped read returns prdata=0.
- Undefined:
  - pslverr is tied 0.
  - Unmapped writes still suppress reg_wr_en.
  - Unmapped reads return 0.
  - No error is ever signalled.

Decomposition:
- Shared package ictc_pkg holds:
  - the FSM state enum (IDLE/WAIT/DONE);
  - ICTC_ADDR_W=12 and ICTC_DATA_W=32;
  - the register address constants, including TIER_ADDR=12'h14.
- One sub-module is natural: ictc_addr_decode, a combinational addr -> mapped/unmapped check shared with future bank-side decoders.

Test Plan:
- Write, WAIT_STATES=1: APB write paddr=0x14, pwdata=0x1. Pready rises exactly 2 cycles after setup; reg_wr_en pulses 1 cycle with reg_addr=0x14 and reg_wr_data=0x1; TIER readback gives prdata=0x00000001.
- Read, WAIT_STATES=3: bank returns 0xA5A5_0001 at 0x14; APB read. Pready rises 4 cycles after setup; prdata=0xA5A5_0001; reg_wr_en never asserted.
- Abort: psel deasserted in the 2nd WAIT cycle of a write to 0x14 with data 0x1. No reg_wr_en, pready stays 0, and the next transfer completes normally.
- Error with ICTC_APB_PSLVERR_EN defined: write to 0x20 and to 0x15. Pslverr=1 with pready=1, no reg_wr_en; a read of 0x20 returns prdata=0 and pslverr=1. Without the macro, pslverr=0.
- Back-to-back: write 0x14=0x1, then immediately read 0x14. Both complete; the read returns 0x00000001.
- Reset mid-operation: assert rst_n low during WAIT. All outputs return to reset values at once; after release, a fresh read of 0x14 returns 0.
